data_mem_responder: RTL and testbench

//  Responder end of the CPU data-memory interface: accepts the CPU's read/write strobes, access size and

---
 rtl/mem_pkg.sv | 43 ++++
 rtl/mem_lane_align.sv | 60 ++++++
 rtl/data_mem_responder.sv | 163 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder.
//   mem_size_t : access-size encoding as driven on mem_size
//   state_t    : responder FSM states
//   byte_lane / half_lane : which lane of a 32-bit word an offset selects
//   addr_misaligned       : alignment check for a given size and offset
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_WORD = 2'b00,
        SZ_HALF = 2'b01,
        SZ_BYTE = 2'b10,
        SZ_ILL  = 2'b11
    } mem_size_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_STALL,
        ST_COMMIT,
        ST_DONE
    } state_t;

    localparam int WAIT_W = 4;

    // Little-endian byte lane: byte k lives in word[8k+7:8k].
    function automatic logic [1:0] byte_lane(input logic [1:0] off);
        return off;
    endfunction

    // Half lane: half h lives in word[16h+15:16h].
    function automatic logic half_lane(input logic [1:0] off);
        return off[1];
    endfunction

    function automatic logic addr_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        if (size == SZ_HALF) bad = off[0];
        if (size == SZ_WORD) bad = |off;
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane alignment between a 32-bit RAM word and the CPU.
// Ports:
//   word       in  32  word fetched from RAM
//   size       in  2   access size (mem_size_t encoding)
//   sign       in  1   sign-extend sub-word loads
//   byte_off   in  2   byte offset within the word
//   wdata      in  32  store data (byte/half taken from the low bits)
//   load_data  out 32  selected lane, extended to 32 bits
//   store_word out 32  fetched word with the store lane(s) merged in
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [1:0]  byte_off,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [3:0]  byte_en;
    logic [31:0] wdata_rep;

    assign byte_sel = word[{byte_lane(byte_off), 3'b000} +: 8];
    assign half_sel = word[{half_lane(byte_off), 4'b0000} +: 16];

    always_comb begin
        load_data = word;
        byte_en   = 4'b1111;
        wdata_rep = wdata;
        case (size)
            SZ_BYTE: begin
                load_data = {{24{sign & byte_sel[7]}}, byte_sel};
                byte_en   = 4'b0001 << byte_lane(byte_off);
                wdata_rep = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                load_data = {{16{sign & half_sel[15]}}, half_sel};
                byte_en   = half_lane(byte_off) ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
            end
            default: begin
                load_data = word;
                byte_en   = 4'b1111;
                wdata_rep = wdata;
            end
        endcase
    end

    // Store data is replicated across all lanes, so the byte enable alone picks the lane.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_merge
            assign store_word[8*gi +: 8] = byte_en[gi] ? wdata_rep[8*gi +: 8] : word[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the CPU data-memory interface in front of a word-wide RAM.
// Every access reads the addressed word first; stores merge their lane into it
// and write the whole word back (read-modify-write).
// Ports:
//   clk       in  1   clock, rising edge
//   rst       in  1   synchronous active-high reset
//   mem_rd    in  1   read request, held until ready
//   mem_wr    in  1   write request, held until ready
//   mem_size  in  2   00 word, 01 half, 10 byte, 11 illegal
//   mem_sign  in  1   sign-extend sub-word loads
//   addr      in  32  absolute byte address (includes BASE_ADDR)
//   wdata     in  32  store data
//   rdata     out 32  load data while ready=1 and err=0, else 0
//   ready     out 1   one-cycle completion pulse
//   err       out 1   access rejected (qualifies ready)
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int          DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [1:0]  mem_size,
    input  logic        mem_sign,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0] ram [DEPTH];
    logic [31:0] ram_q;

    state_t              state_reg, state_next;
    logic [WAIT_W-1:0]   wait_cnt_reg, wait_cnt_next;

    logic                is_read_reg;
    logic [1:0]          size_reg;
    logic                sign_reg;
    logic [AW+1:0]       off_reg;
    logic [31:0]         wdata_reg;
    logic                err_reg;
    logic [31:0]         rdata_reg;

    logic                req;
    logic [31:0]         offset;
    logic                req_err;
    logic [AW-1:0]       ram_addr;
    logic                ram_we;
    logic [31:0]         load_data;
    logic [31:0]         store_word;

    assign req    = mem_rd | mem_wr;
    // Unsigned subtraction: addresses below BASE_ADDR wrap to huge offsets
    // and fall out through the range check.
    assign offset = addr - BASE_ADDR;

    assign req_err = (mem_rd & mem_wr)
                   | (mem_size == SZ_ILL)
                   | addr_misaligned(mem_size, offset[1:0])
                   | (offset >= 32'(DEPTH * 4));

    assign ram_addr = off_reg[AW+1:2];
    // rst gates the write so a reset on the commit edge leaves the RAM untouched.
    assign ram_we   = !rst && (state_reg == ST_COMMIT) && !is_read_reg;

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (req) state_next = req_err ? ST_DONE : ST_FETCH;
            end
            ST_FETCH: begin
                if (WAIT_CYCLES == 0) begin
                    state_next = ST_COMMIT;
                end else begin
                    state_next    = ST_STALL;
                    wait_cnt_next = WAIT_W'(WAIT_CYCLES);
                end
            end
            ST_STALL: begin
                if (wait_cnt_reg <= 1) begin
                    state_next    = ST_COMMIT;
                    wait_cnt_next = '0;
                end else begin
                    wait_cnt_next = wait_cnt_reg - 1'b1;
                end
            end
            ST_COMMIT: state_next = ST_DONE;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            wait_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    // Request latch and result register; everything after IDLE uses these copies.
    always_ff @(posedge clk) begin
        if (rst) begin
            is_read_reg <= 1'b0;
            size_reg    <= SZ_WORD;
            sign_reg    <= 1'b0;
            off_reg     <= '0;
            wdata_reg   <= '0;
            err_reg     <= 1'b0;
            rdata_reg   <= '0;
        end else begin
            if (state_reg == ST_IDLE && req) begin
                is_read_reg <= mem_rd;
                size_reg    <= mem_size;
                sign_reg    <= mem_sign;
                off_reg     <= offset[AW+1:0];
                wdata_reg   <= wdata;
                err_reg     <= req_err;
                rdata_reg   <= '0;
            end
            if (state_reg == ST_COMMIT) begin
                rdata_reg <= is_read_reg ? load_data : 32'h0;
            end
        end
    end

    // Block RAM: registered read in FETCH, whole-word write in COMMIT. No reset.
    always_ff @(posedge clk) begin
        if (state_reg == ST_FETCH) begin
            ram_q <= ram[ram_addr];
        end
        if (ram_we) begin
            ram[ram_addr] <= store_word;
        end
    end

    mem_lane_align u_align (
        .word       (ram_q),
        .size       (size_reg),
        .sign       (sign_reg),
        .byte_off   (off_reg[1:0]),
        .wdata      (wdata_reg),
        .load_data  (load_data),
        .store_word (store_word)
    );

    assign ready = (state_reg == ST_DONE);
    assign err   = ready & err_reg;
    assign rdata = (ready && !err_reg) ? rdata_reg : 32'h0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: one instance with no wait states,
// one with three. Stimulus pushes the expected response (err, rdata, due cycle)
// into a per-instance queue; a monitor per instance pops and compares on ready.
module tb_data_mem_responder;
    import mem_pkg::*;

    localparam logic [31:0] BASE = 32'h1001_0000;
    localparam int          W1   = 3;

    typedef struct {
        string       name;
        logic        err;
        logic [31:0] rdata;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst0 = 1'b1, rst1 = 1'b1;
    logic        mem_rd0 = 1'b0, mem_wr0 = 1'b0, mem_rd1 = 1'b0, mem_wr1 = 1'b0;
    logic [1:0]  mem_size = 2'b00;
    logic        mem_sign = 1'b0;
    logic [31:0] addr = 32'h0, wdata = 32'h0;
    logic [31:0] rdata0, rdata1;
    logic        ready0, ready1, err0, err1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_responder #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst0), .mem_rd(mem_rd0), .mem_wr(mem_wr0),
        .mem_size(mem_size), .mem_sign(mem_sign), .addr(addr), .wdata(wdata),
        .rdata(rdata0), .ready(ready0), .err(err0)
    );

    data_mem_responder #(.WAIT_CYCLES(W1)) dut1 (
        .clk(clk), .rst(rst1), .mem_rd(mem_rd1), .mem_wr(mem_wr1),
        .mem_size(mem_size), .mem_sign(mem_sign), .addr(addr), .wdata(wdata),
        .rdata(rdata1), .ready(ready1), .err(err1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Monitors
    always @(negedge clk) begin
        exp_t e;
        if (!rst0 && ready0) begin
            if (q0.size() == 0) begin
                checks++; failures++;
                $display("FAIL dut0_unexpected_ready actual=1 required=0 cyc=%0d", cyc);
            end else begin
                e = q0.pop_front();
                $display("dut0 %s err=%0b rdata=%h cyc=%0d", e.name, err0, rdata0, cyc);
                chk({"dut0_", e.name, "_err"}, {31'b0, err0}, {31'b0, e.err});
                chk({"dut0_", e.name, "_rdata"}, rdata0, e.rdata);
                chk({"dut0_", e.name, "_cycle"}, 32'(cyc), 32'(e.due));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst1 && ready1) begin
            if (q1.size() == 0) begin
                checks++; failures++;
                $display("FAIL dut1_unexpected_ready actual=1 required=0 cyc=%0d", cyc);
            end else begin
                e = q1.pop_front();
                $display("dut1 %s err=%0b rdata=%h cyc=%0d", e.name, err1, rdata1, cyc);
                chk({"dut1_", e.name, "_err"}, {31'b0, err1}, {31'b0, e.err});
                chk({"dut1_", e.name, "_rdata"}, rdata1, e.rdata);
                chk({"dut1_", e.name, "_cycle"}, 32'(cyc), 32'(e.due));
            end
        end
    end

    task automatic wait_ready(input int d, input string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if ((d == 0 && ready0) || (d == 1 && ready1)) seen = 1'b1;
        end
        if (d == 0) begin mem_rd0 = 1'b0; mem_wr0 = 1'b0; end
        else        begin mem_rd1 = 1'b0; mem_wr1 = 1'b0; end
        if (!seen) begin
            checks++; failures++;
            $display("FAIL %s_timeout actual=no_ready required=ready", nm);
            if (d == 0 && q0.size() > 0) void'(q0.pop_front());
            if (d == 1 && q1.size() > 0) void'(q1.pop_front());
        end
    endtask

    // One complete access; expected latency is 1 for errors, 3+WAIT_CYCLES otherwise.
    task automatic access(input int d, input logic rd, input logic wr, input logic [1:0] sz,
                          input logic sg, input logic [31:0] a, input logic [31:0] wd,
                          input logic xerr, input logic [31:0] xdata, input string nm);
        exp_t e;
        int   lat;
        @(negedge clk);
        lat = xerr ? 1 : (3 + (d == 0 ? 0 : W1));
        e = '{name: nm, err: xerr, rdata: xdata, due: cyc + lat};
        if (d == 0) q0.push_back(e); else q1.push_back(e);
        mem_size = sz; mem_sign = sg; addr = a; wdata = wd;
        if (d == 0) begin mem_rd0 = rd; mem_wr0 = wr; end
        else        begin mem_rd1 = rd; mem_wr1 = wr; end
        wait_ready(d, nm);
    endtask

    initial begin
        exp_t e;
        int   cnt;

        repeat (3) @(negedge clk);
        rst0 = 1'b0; rst1 = 1'b0;
        @(negedge clk);
        chk("reset_ready0", {31'b0, ready0}, 32'h0);
        chk("reset_err0", {31'b0, err0}, 32'h0);
        chk("reset_rdata0", rdata0, 32'h0);
        chk("reset_ready1", {31'b0, ready1}, 32'h0);

        // Word write and read back
        access(0, 0, 1, SZ_WORD, 0, BASE,      32'hDEAD_BEEF, 0, 32'h0,         "wr_word0");
        access(0, 1, 0, SZ_WORD, 0, BASE,      32'h0,         0, 32'hDEAD_BEEF, "rd_word0");

        // Sub-word stores and loads on word 1
        access(0, 0, 1, SZ_WORD, 0, BASE + 4,  32'h1122_3344, 0, 32'h0,         "wr_word1");
        access(0, 0, 1, SZ_BYTE, 0, BASE + 6,  32'h1234_5680, 0, 32'h0,         "wr_byte2");
        access(0, 1, 0, SZ_BYTE, 1, BASE + 6,  32'h0,         0, 32'hFFFF_FF80, "rd_byte2_s");
        access(0, 1, 0, SZ_BYTE, 0, BASE + 6,  32'h0,         0, 32'h0000_0080, "rd_byte2_u");
        access(0, 1, 0, SZ_WORD, 0, BASE + 4,  32'h0,         0, 32'h1180_3344, "rd_word1");
        access(0, 1, 0, SZ_HALF, 1, BASE + 6,  32'h0,         0, 32'h0000_1180, "rd_half1_s");
        access(0, 1, 0, SZ_BYTE, 1, BASE + 7,  32'h0,         0, 32'h0000_0011, "rd_byte3_s");
        access(0, 0, 1, SZ_HALF, 0, BASE + 4,  32'hAAAA_C001, 0, 32'h0,         "wr_half0");
        access(0, 1, 0, SZ_HALF, 1, BASE + 4,  32'h0,         0, 32'hFFFF_C001, "rd_half0_s");
        access(0, 1, 0, SZ_HALF, 0, BASE + 4,  32'h0,         0, 32'h0000_C001, "rd_half0_u");
        access(0, 1, 0, SZ_BYTE, 1, BASE + 5,  32'h0,         0, 32'hFFFF_FFC0, "rd_byte1_s");
        access(0, 1, 0, SZ_WORD, 0, BASE + 4,  32'h0,         0, 32'h1180_C001, "rd_word1_b");

        // Rejected accesses leave the RAM alone
        access(0, 1, 0, SZ_HALF, 0, BASE + 1,  32'h0,         1, 32'h0,         "err_half_odd");
        access(0, 1, 0, SZ_WORD, 0, BASE + 2,  32'h0,         1, 32'h0,         "err_word_mis");
        access(0, 0, 1, SZ_WORD, 0, BASE + 2,  32'h0BAD_0BAD, 1, 32'h0,         "err_wr_mis");
        access(0, 1, 0, SZ_ILL,  0, BASE,      32'h0,         1, 32'h0,         "err_size11");
        access(0, 1, 0, SZ_WORD, 0, 32'h1000_FFFC, 32'h0,     1, 32'h0,         "err_below");
        access(0, 1, 0, SZ_WORD, 0, BASE + 4096, 32'h0,       1, 32'h0,         "err_above");
        access(0, 1, 1, SZ_WORD, 0, BASE,      32'h0000_0000, 1, 32'h0,         "err_rd_wr");
        access(0, 1, 0, SZ_WORD, 0, BASE,      32'h0,         0, 32'hDEAD_BEEF, "rd_word0_kept");

        // Last word in range
        access(0, 0, 1, SZ_WORD, 0, BASE + 4092, 32'hCAFE_F00D, 0, 32'h0,       "wr_last");
        access(0, 1, 0, SZ_WORD, 0, BASE + 4092, 32'h0,       0, 32'hCAFE_F00D, "rd_last");

        // Three wait states
        access(1, 0, 1, SZ_WORD, 0, BASE + 8,  32'h55AA_1234, 0, 32'h0,         "w3_wr_word2");
        access(1, 1, 0, SZ_HALF, 0, BASE + 9,  32'h0,         1, 32'h0,         "w3_err_half");

        // Inputs toggled during STALL must not affect the result
        @(negedge clk);
        e = '{name: "w3_rd_toggle", err: 1'b0, rdata: 32'h55AA_1234, due: cyc + 3 + W1};
        q1.push_back(e);
        mem_size = SZ_WORD; mem_sign = 1'b0; addr = BASE + 8; wdata = 32'h0; mem_rd1 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        addr = BASE; mem_size = SZ_BYTE; mem_sign = 1'b1; wdata = 32'hFFFF_FFFF; mem_wr1 = 1'b1;
        @(negedge clk);
        mem_wr1 = 1'b0; addr = 32'h0;
        wait_ready(1, "w3_rd_toggle");

        // Reset during STALL of a byte write
        @(negedge clk);
        mem_size = SZ_BYTE; mem_sign = 1'b0; addr = BASE + 8; wdata = 32'h0000_00EE; mem_wr1 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst1 = 1'b1; mem_wr1 = 1'b0;
        @(negedge clk);
        rst1 = 1'b0;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (ready1) cnt++;
        end
        chk("w3_rst_no_ready", 32'(cnt), 32'h0);
        access(1, 1, 0, SZ_WORD, 0, BASE + 8,  32'h0,         0, 32'h55AA_1234, "w3_rd_after_rst");
        access(1, 1, 0, SZ_BYTE, 0, BASE + 8,  32'h0,         0, 32'h0000_0034, "w3_rd_byte0");

        repeat (3) @(negedge clk);
        if (q0.size() != 0 || q1.size() != 0) begin
            checks++; failures++;
            $display("FAIL pending_responses actual=%0d required=0", q0.size() + q1.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
